// File: rtl/alu_mode_ctrl.sv
// alu_mode_ctrl: debounced pushbuttons step the ALU mode (a) and operation (b); also a free-running cycle counter
module alu_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 MAX10_CLK1_50,
    input  logic                 rst,
    input  logic [1:0]           KEY,
    output logic [1:0]           a,
    output logic [1:0]           b,
    output logic [CNT_WIDTH-1:0] clk_cnt,
    output logic                 sel_changed
);
    localparam logic [1:0] ARITH = 2'd0;
    localparam logic [1:0] LOGIC = 2'd1;
    localparam logic [1:0] COMP  = 2'd2;
    localparam logic [1:0] MAGIC = 2'd3;
    localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

    logic [1:0]  s1, s2, stable, stable_d, press;
    logic [19:0] cnt [2];
    logic [1:0]  next_mode;

    always_comb
        next_mode = (a == ARITH) ? LOGIC : (a == LOGIC) ? COMP : (a == COMP) ? MAGIC : ARITH;

    always_ff @(posedge MAX10_CLK1_50) begin
        if (rst) begin
            s1       <= 2'b11;
            s2       <= 2'b11;
            stable   <= 2'b11;
            stable_d <= 2'b11;
            press    <= 2'b00;
            cnt[0]   <= '0;
            cnt[1]   <= '0;
        end else begin
            s1       <= KEY;
            s2       <= s1;
            stable_d <= stable;
            press    <= stable_d & ~stable;
            // any cycle matching the stable level restarts the count
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == stable[i])
                    cnt[i] <= '0;
                else if (cnt[i] == DB_LAST) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else
                    cnt[i] <= cnt[i] + 20'd1;
            end
        end
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (rst) begin
            a           <= ARITH;
            b           <= 2'd0;
            clk_cnt     <= '0;
            sel_changed <= 1'b0;
        end else begin
            clk_cnt     <= clk_cnt + CNT_WIDTH'(1);
            sel_changed <= |press;
            // a mode step overrides a simultaneous operation step
            if (press[1]) begin
                a <= next_mode;
                b <= 2'd0;
            end else if (press[0])
                b <= b + 2'd1;
        end
    end
endmodule
